// File: rtl/regfile_stream_loader.sv
// -----------------------------------------------------------------------------
// regfile_stream_loader
//
// Moves whole registers between a 32-bit beat stream and a 4 x 512-bit register
// file. It drives the register file's write port and addresses its read port.
//
//   LOAD  : collects BEATS stream words (beat 0 = bits [BEAT_W-1:0]) into one
//           DATA_W value, then writes it to the register file with a single
//           one-cycle rf_write pulse.
//   STORE : reads one register into a shift register, then sends it out one beat
//           at a time, least-significant beat first.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only when idle
//   cmd_store, cmd_reg    0 = LOAD, 1 = STORE; index of the target register
//   in_valid/in_ready     inbound LOAD beats, in_data
//   out_valid/out_ready   outbound STORE beats, out_data
//   rf_addr               register file address for reads and writes
//   rf_write, rf_wdata    register file write strobe and data
//   rf_rdata              register file combinational read data at rf_addr
//   busy                  high whenever a command is in progress
//   done                  one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module regfile_stream_loader #(
  parameter int DATA_W = 512,
  parameter int BEAT_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_store,
  input  logic [ADDR_W-1:0] cmd_reg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy,
  output logic              done
);

  localparam int BEATS = DATA_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_STORE_RD,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;

  // Handshake and status outputs are flops decoded from the next state, so
  // they are glitch-free and line up exactly with the state they describe.
  logic cmd_ready_q, in_ready_q, out_valid_q, rf_write_q, busy_q, done_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    shreg_d = shreg_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          // The address is captured here and held until the next command, so
          // it is already stable for the read in S_STORE_RD.
          addr_d  = cmd_reg;
          cnt_d   = '0;
          state_d = cmd_store ? S_STORE_RD : S_LOAD;
        end
      end

      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          asm_d[int'(cnt_q) * BEAT_W +: BEAT_W] = in_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_WRITE;
        end
      end

      S_WRITE: state_d = S_DONE;

      S_STORE_RD: begin
        shreg_d = rf_rdata;
        cnt_d   = '0;
        state_d = S_STORE;
      end

      S_STORE: begin
        if (out_valid_q && out_ready) begin
          shreg_d = shreg_q >> BEAT_W;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: non-blocking assignments throughout, so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the wide assembly and shift registers are cleared on reset too,
      // so no data from an aborted command can appear on rf_wdata or out_data.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      asm_q       <= '0;
      shreg_q     <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      rf_write_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      asm_q       <= asm_d;
      shreg_q     <= shreg_d;
      cmd_ready_q <= (state_d == S_IDLE);
      in_ready_q  <= (state_d == S_LOAD);
      out_valid_q <= (state_d == S_STORE);
      rf_write_q  <= (state_d == S_WRITE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = shreg_q[BEAT_W-1:0];
  assign rf_addr   = addr_q;
  assign rf_write  = rf_write_q;
  assign rf_wdata  = asm_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
